// File: rtl/ntt_pairwm_ctrl.sv
`default_nettype none
// ntt_pairwm_ctrl: issue/track sequencer for the MLKEM Karatsuba pairwise multiplier datapath.
// Rev 1.0 -- optional perf counters enabled by ABR_PWM_CTRL_PERF_CNT_EN.
module ntt_pairwm_ctrl #(
  parameter int NUM_PAIRS  = 128,
  parameter int ADDR_W     = 7,
  parameter int MEM_RD_LAT = 1,
  parameter int PWM_LAT    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              zeroize,
  input  logic              start_i,
  input  logic              accumulate_i,
  input  logic              src_sampler_i,
  input  logic [ADDR_W-1:0] a_base_i,
  input  logic [ADDR_W-1:0] b_base_i,
  input  logic [ADDR_W-1:0] w_base_i,
  input  logic [ADDR_W-1:0] d_base_i,
  input  logic              sampler_valid_i,
  output logic              sampler_ready_o,
  output logic              a_rd_en_o,
  output logic              b_rd_en_o,
  output logic              w_rd_en_o,
  output logic [ADDR_W-1:0] a_rd_addr_o,
  output logic [ADDR_W-1:0] b_rd_addr_o,
  output logic [ADDR_W-1:0] w_rd_addr_o,
  output logic              zeta_rd_en_o,
  output logic [ADDR_W-1:0] zeta_addr_o,
  output logic              pwm_accumulate_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              busy_o,
  output logic              done_o
`ifdef ABR_PWM_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       cycle_cnt_o
`endif
);

  localparam int CNT_W = $clog2(NUM_PAIRS + 1);
  // One extra stage so the accumulate path (one cycle longer) can tap the last bit.
  localparam int VLD_W = MEM_RD_LAT + PWM_LAT + 1;
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(NUM_PAIRS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              acc_q, acc_d, src_q, src_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d, b_base_q, b_base_d;
  logic [ADDR_W-1:0] w_base_q, w_base_d, d_base_q, d_base_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [VLD_W-1:0]  vld_q, vld_d;
  logic              busy, issue, wr_fire, start_ok;
  logic [ADDR_W-1:0] pair_idx, wr_idx;

  assign busy     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign issue    = (state_q == S_ISSUE) && (!src_q || sampler_valid_i);
  assign wr_fire  = busy && (acc_q ? vld_q[VLD_W-1] : vld_q[VLD_W-2]);
  assign start_ok = (state_q == S_IDLE) && start_i;
  assign pair_idx = ADDR_W'(issue_cnt_q);
  assign wr_idx   = ADDR_W'(wr_cnt_q);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    src_d       = src_q;
    a_base_d    = a_base_q;
    b_base_d    = b_base_q;
    w_base_d    = w_base_q;
    d_base_d    = d_base_q;
    issue_cnt_d = issue_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    vld_d       = {vld_q[VLD_W-2:0], issue};
    if (issue)   issue_cnt_d = issue_cnt_q + CNT_W'(1);
    if (wr_fire) wr_cnt_d    = wr_cnt_q + CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_ISSUE;
          acc_d       = accumulate_i;
          src_d       = src_sampler_i;
          a_base_d    = a_base_i;
          b_base_d    = b_base_i;
          w_base_d    = w_base_i;
          d_base_d    = d_base_i;
          issue_cnt_d = '0;
          wr_cnt_d    = '0;
          vld_d       = '0;
        end
      end
      S_ISSUE: if (issue && issue_cnt_q == LAST_PAIR) state_d = S_DRAIN;
      S_DRAIN: if (wr_fire && wr_cnt_q == LAST_PAIR) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (zeroize) begin
      state_d     = S_IDLE;
      acc_d       = 1'b0;
      src_d       = 1'b0;
      a_base_d    = '0;
      b_base_d    = '0;
      w_base_d    = '0;
      d_base_d    = '0;
      issue_cnt_d = '0;
      wr_cnt_d    = '0;
      vld_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      acc_q       <= 1'b0;
      src_q       <= 1'b0;
      a_base_q    <= '0;
      b_base_q    <= '0;
      w_base_q    <= '0;
      d_base_q    <= '0;
      issue_cnt_q <= '0;
      wr_cnt_q    <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      src_q       <= src_d;
      a_base_q    <= a_base_d;
      b_base_q    <= b_base_d;
      w_base_q    <= w_base_d;
      d_base_q    <= d_base_d;
      issue_cnt_q <= issue_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      vld_q       <= vld_d;
    end
  end

  // Addresses are forced to zero whenever their strobe is low.
  assign sampler_ready_o  = issue && src_q;
  assign a_rd_en_o        = issue;
  assign b_rd_en_o        = issue && !src_q;
  assign w_rd_en_o        = issue && acc_q;
  assign zeta_rd_en_o     = issue;
  assign a_rd_addr_o      = a_rd_en_o ? a_base_q + pair_idx : '0;
  assign b_rd_addr_o      = b_rd_en_o ? b_base_q + pair_idx : '0;
  assign w_rd_addr_o      = w_rd_en_o ? w_base_q + pair_idx : '0;
  assign zeta_addr_o      = issue ? pair_idx : '0;
  assign wr_en_o          = wr_fire;
  assign wr_addr_o        = wr_fire ? d_base_q + wr_idx : '0;
  assign pwm_accumulate_o = busy && acc_q;
  assign busy_o           = busy;
  assign done_o           = (state_q == S_DONE);

`ifdef ABR_PWM_CTRL_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    if (start_ok) begin
      stall_cnt_d = '0;
      cycle_cnt_d = '0;
    end else begin
      if ((state_q == S_ISSUE) && !issue && (stall_cnt_q != 16'hFFFF))
        stall_cnt_d = stall_cnt_q + 16'd1;
      if (busy && (cycle_cnt_q != 16'hFFFF))
        cycle_cnt_d = cycle_cnt_q + 16'd1;
    end
    if (zeroize) begin
      stall_cnt_d = '0;
      cycle_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign cycle_cnt_o = cycle_cnt_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ntt_pairwm_ctrl.sv
`default_nettype none
// tb_ntt_pairwm_ctrl: randomized directed jobs checked against a cycle-timeline reference model.
module tb_ntt_pairwm_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, zeroize, start_i, accumulate_i, src_sampler_i, sampler_valid_i;
  logic [6:0] a_base_i, b_base_i, w_base_i, d_base_i;
  logic       sampler_ready_o, a_rd_en_o, b_rd_en_o, w_rd_en_o, zeta_rd_en_o;
  logic [6:0] a_rd_addr_o, b_rd_addr_o, w_rd_addr_o, zeta_addr_o, wr_addr_o;
  logic       pwm_accumulate_o, wr_en_o, busy_o, done_o;
`ifdef ABR_PWM_CTRL_PERF_CNT_EN
  logic [15:0] stall_cnt_o, cycle_cnt_o;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ntt_pairwm_ctrl dut (
    .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .start_i(start_i),
    .accumulate_i(accumulate_i), .src_sampler_i(src_sampler_i),
    .a_base_i(a_base_i), .b_base_i(b_base_i), .w_base_i(w_base_i), .d_base_i(d_base_i),
    .sampler_valid_i(sampler_valid_i), .sampler_ready_o(sampler_ready_o),
    .a_rd_en_o(a_rd_en_o), .b_rd_en_o(b_rd_en_o), .w_rd_en_o(w_rd_en_o),
    .a_rd_addr_o(a_rd_addr_o), .b_rd_addr_o(b_rd_addr_o), .w_rd_addr_o(w_rd_addr_o),
    .zeta_rd_en_o(zeta_rd_en_o), .zeta_addr_o(zeta_addr_o),
    .pwm_accumulate_o(pwm_accumulate_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
`ifdef ABR_PWM_CTRL_PERF_CNT_EN
    .stall_cnt_o(stall_cnt_o), .cycle_cnt_o(cycle_cnt_o),
`endif
    .busy_o(busy_o), .done_o(done_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({a_rd_en_o, a_rd_addr_o, b_rd_en_o, b_rd_addr_o, w_rd_en_o, w_rd_addr_o,
                zeta_rd_en_o, zeta_addr_o, wr_en_o, wr_addr_o,
                sampler_ready_o, pwm_accumulate_o, busy_o, done_o});
  endfunction

  // vmode: 0 = sampler always valid, 1 = toggle 1,0,1,0, 2 = random (~75% valid)
  // abort_kind: 0 = none, 1 = zeroize on 50th issue, 2 = async reset mid-drain
  task automatic run_job(input bit acc, input bit src, input logic [6:0] ab, input logic [6:0] bb,
                         input logic [6:0] wb, input logic [6:0] db, input int vmode,
                         input int abort_kind);
    int         d_lat, n_iss, n_wr, stalls, done_c, abort_c;
    int         pend[$];
    bit         aborted, finished, isq, iss, v, wr_e, busy_e, done_e;
    logic [6:0] n7, w7, eb, ew;
    d_lat = 5 + int'(acc);
    n_iss = 0; n_wr = 0; stalls = 0; done_c = -1; abort_c = 0;
    aborted = 1'b0; finished = 1'b0;
    @(negedge clk);
    accumulate_i = acc; src_sampler_i = src;
    a_base_i = ab; b_base_i = bb; w_base_i = wb; d_base_i = db;
    start_i = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      reset_n = 1'b1;
      zeroize = 1'b0;
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((c % 2) == 1) : ($urandom_range(0, 3) != 0);
      sampler_valid_i = v;
      start_i = !aborted && ((c == 10) || (c == done_c));
      accumulate_i  = 1'($urandom_range(0, 1));
      src_sampler_i = 1'($urandom_range(0, 1));
      a_base_i = 7'($urandom); b_base_i = 7'($urandom);
      w_base_i = 7'($urandom); d_base_i = 7'($urandom);
      if (abort_kind == 1 && c == 50) zeroize = 1'b1;
      #1;
      if (aborted) begin
        chk("abort_quiet", all_outs(), 64'd0);
`ifdef ABR_PWM_CTRL_PERF_CNT_EN
        chk("abort_perf", 64'({stall_cnt_o, cycle_cnt_o}), 64'd0);
`endif
      end else begin
        isq    = (n_iss < 128);
        iss    = isq && (!src || v);
        wr_e   = (pend.size() > 0) && (pend[0] == c);
        busy_e = (done_c < 0) || (c < done_c);
        done_e = (c == done_c);
        chk("ctl", 64'({a_rd_en_o, b_rd_en_o, w_rd_en_o, zeta_rd_en_o, sampler_ready_o,
                        wr_en_o, busy_o, done_o, pwm_accumulate_o}),
            64'({iss, iss && !src, iss && acc, iss, iss && src,
                 wr_e, busy_e, done_e, acc && busy_e}));
        if (iss) begin
          n7 = 7'(n_iss);
          eb = src ? 7'd0 : bb + n7;
          ew = acc ? wb + n7 : 7'd0;
          chk("rd_addr",
              64'({a_rd_addr_o, src ? 7'd0 : b_rd_addr_o, acc ? w_rd_addr_o : 7'd0, zeta_addr_o}),
              64'({ab + n7, eb, ew, n7}));
          pend.push_back(c + d_lat);
          n_iss++;
        end else if (isq) begin
          stalls++;
        end
        if (wr_e) begin
          w7 = db + 7'(n_wr);
          chk("wr_addr", 64'(wr_addr_o), 64'(w7));
          void'(pend.pop_front());
          n_wr++;
          if (n_wr == 128) done_c = c + 1;
        end
`ifdef ABR_PWM_CTRL_PERF_CNT_EN
        if (done_c > 0 && c >= done_c) begin
          chk("stall_cnt", 64'(stall_cnt_o), 64'(stalls));
          chk("cycle_cnt", 64'(cycle_cnt_o), 64'(done_c - 1));
        end
`endif
        if (abort_kind == 1 && c == 50) begin
          aborted = 1'b1; abort_c = c;
        end
        if (abort_kind == 2 && n_iss == 128 && pend.size() == 2) begin
          reset_n = 1'b0;
          #1;
          chk("async_rst", all_outs(), 64'd0);
          aborted = 1'b1; abort_c = c;
        end
      end
      if ((aborted && c >= abort_c + 10) || (!aborted && done_c > 0 && c == done_c + 3)) begin
        finished = 1'b1;
        break;
      end
    end
    start_i = 1'b0;
    chk("job_finished", 64'(finished), 64'd1);
  endtask

  initial begin
    reset_n = 1'b0; zeroize = 1'b0; start_i = 1'b0; accumulate_i = 1'b0;
    src_sampler_i = 1'b0; sampler_valid_i = 1'b0;
    a_base_i = '0; b_base_i = '0; w_base_i = '0; d_base_i = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", all_outs(), 64'd0);
`ifdef ABR_PWM_CTRL_PERF_CNT_EN
    chk("reset_perf", 64'({stall_cnt_o, cycle_cnt_o}), 64'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    run_job(1'b0, 1'b0, 7'h00, 7'h00, 7'h00, 7'h00, 0, 0);
    run_job(1'b1, 1'b0, 7'($urandom), 7'($urandom), 7'h40, 7'($urandom), 0, 0);
    run_job(1'b0, 1'b1, 7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 1, 0);
    run_job(1'b1, 1'b1, 7'($urandom), 7'($urandom), 7'($urandom), 7'h7E, 2, 0);
    run_job(1'b0, 1'b0, 7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 0, 1);
    run_job(1'b1, 1'b1, 7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 2, 0);
    run_job(1'b1, 1'b0, 7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 0, 2);
    run_job(1'b0, 1'b1, 7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 2, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
